// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// State encoding, address/instruction widths and default vectors.
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;
    localparam logic [ADDR_W-1:0] IRQ_VECTOR   = 16'h0100;
    localparam logic [ADDR_W-1:0] INSTR_BYTES  = 16'd2;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_HALT
    } state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register between fetch and decode.
// Ports: load/ld_data/ld_pc fill, flush drops, ready consumes; valid/data/pc out.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic [ADDR_W-1:0]  ld_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            pc    <= ld_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: steers the external PC, issues imem requests, feeds decode.
// Ports: pc_in/pc_jump_to/pc_target (PC), imem_req_*/imem_resp_* (memory),
// instr_* (decode), redirect_*, irq/irq_ack/irq_epc, halt_req/run.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = fetch_pkg::IRQ_VECTOR,
    parameter logic [ADDR_W-1:0] INSTR_BYTES  = fetch_pkg::INSTR_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_jump_to,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               irq,
    output logic               irq_ack,
    output logic [ADDR_W-1:0]  irq_epc,
    input  logic               halt_req,
    input  logic               run
);

    state_t            state, state_nxt;
    logic              drop, drop_nxt;
    logic              halt_pend, halt_pend_nxt;
    logic              irq_blk;
    logic              irq_take;
    logic              irq_ok;
    logic              buf_free;
    logic              buf_load;
    logic              buf_flush;
    logic              req_fire;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] redir_pc;

    // Redirect targets are forced onto an instruction boundary.
    assign redir_pc = redirect_target & ~(INSTR_BYTES - 16'd1);

    assign buf_free      = !instr_valid || instr_ready;
    assign irq_ok        = irq && !irq_blk;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc_in;
    assign irq_ack       = irq_take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_BOOT;
            drop      <= 1'b0;
            halt_pend <= 1'b0;
            irq_blk   <= 1'b0;
            irq_epc   <= '0;
            req_pc    <= '0;
        end else begin
            state     <= state_nxt;
            drop      <= drop_nxt;
            halt_pend <= halt_pend_nxt;
            irq_blk   <= irq_take;
            if (irq_take) irq_epc <= pc_in;
            if (req_fire) req_pc <= pc_in;
        end
    end

    // PC has no enable: the default is to reload its own value.
    always_comb begin
        state_nxt      = state;
        drop_nxt       = drop;
        halt_pend_nxt  = halt_pend || halt_req;
        pc_jump_to     = 1'b1;
        pc_target      = pc_in;
        imem_req_valid = 1'b0;
        irq_take       = 1'b0;
        buf_load       = 1'b0;
        buf_flush      = 1'b0;
        unique case (state)
            ST_BOOT: begin
                pc_target = RESET_VECTOR;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_target     = redir_pc;
                    buf_flush     = 1'b1;
                    halt_pend_nxt = 1'b0;
                end else if (irq_ok) begin
                    irq_take  = 1'b1;
                    pc_target = IRQ_VECTOR;
                    buf_flush = 1'b1;
                end else if (halt_pend) begin
                    halt_pend_nxt = 1'b0;
                    state_nxt     = ST_HALT;
                end else if (buf_free) begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        pc_jump_to = 1'b0;
                        state_nxt  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_target     = redir_pc;
                    buf_flush     = 1'b1;
                    halt_pend_nxt = 1'b0;
                    // A response landing now belongs to the old path.
                    if (imem_resp_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = ST_FETCH;
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    buf_load  = !drop;
                    drop_nxt  = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (irq_ok) begin
                    irq_take  = 1'b1;
                    pc_target = IRQ_VECTOR;
                    buf_flush = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    fetch_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .flush   (buf_flush),
        .ready   (instr_ready),
        .ld_data (imem_resp_data),
        .ld_pc   (req_pc),
        .valid   (instr_valid),
        .data    (instr_data),
        .pc      (instr_pc)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a PC model and a small imem model.
// Memory returns addr ^ 16'h5A5A after one or two cycles.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        pc_jump_to;
    logic [15:0] pc_target;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [15:0] imem_resp_data;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        irq;
    logic        irq_ack;
    logic [15:0] irq_epc;
    logic        halt_req;
    logic        run;

    logic        lat2;
    logic        inject;
    logic        s1, s2;
    logic [15:0] a1, a2;
    int          cyc;
    int          ack_cnt;
    int          n_vec;
    int          n_bad;

    logic [15:0] req_q[$];
    logic [15:0] ins_pc_q[$];
    logic [15:0] ins_dat_q[$];
    int          ins_cyc_q[$];

    localparam logic [15:0] K = 16'h5A5A;

    fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc),
        .pc_jump_to      (pc_jump_to),
        .pc_target       (pc_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .irq             (irq),
        .irq_ack         (irq_ack),
        .irq_epc         (irq_epc),
        .halt_req        (halt_req),
        .run             (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC: reload on jump_to, otherwise step by 2.
    always @(posedge clk) begin
        pc  <= pc_jump_to ? pc_target : pc + 16'd2;
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        s1 <= imem_req_valid && imem_req_ready;
        a1 <= imem_req_addr;
        s2 <= s1;
        a2 <= a1;
    end

    assign imem_resp_valid = inject || (lat2 ? s2 : s1);
    assign imem_resp_data  = inject ? 16'hDEAD
                           : ((lat2 ? a2 : a1) ^ K);

    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            if (imem_req_valid && imem_req_ready)
                req_q.push_back(imem_req_addr);
            if (instr_valid && instr_ready) begin
                ins_pc_q.push_back(instr_pc);
                ins_dat_q.push_back(instr_data);
                ins_cyc_q.push_back(cyc);
            end
            if (irq_ack) ack_cnt = ack_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pop_req(output logic [15:0] v);
        v = (req_q.size() > 0) ? req_q.pop_front() : 16'hFFFF;
    endtask

    task automatic pop_ins(output logic [15:0] p, output logic [15:0] d,
                           output int c);
        if (ins_pc_q.size() > 0) begin
            p = ins_pc_q.pop_front();
            d = ins_dat_q.pop_front();
            c = ins_cyc_q.pop_front();
        end else begin
            p = 16'hFFFF;
            d = 16'hFFFF;
            c = -100;
        end
    endtask

    task automatic clear_q();
        req_q.delete();
        ins_pc_q.delete();
        ins_dat_q.delete();
        ins_cyc_q.delete();
        ack_cnt = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        irq            = 1'b0;
        halt_req       = 1'b0;
        run            = 1'b0;
        inject         = 1'b0;
        instr_ready    = 1'b1;
        tick(2);
        clear_q();
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] v, p, d;
        int          c0, c1, c2;
        n_vec           = 0;
        n_bad           = 0;
        cyc             = 0;
        pc              = 16'hBEEF;
        imem_req_ready  = 1'b1;
        redirect_target = 16'h0000;
        lat2            = 1'b0;
        s1              = 1'b0;
        s2              = 1'b0;
        a1              = 16'h0;
        a2              = 16'h0;

        // Reset values and straight-line fetch
        reset          = 1'b0;
        redirect_valid = 1'b0;
        irq            = 1'b0;
        halt_req       = 1'b0;
        run            = 1'b0;
        inject         = 1'b0;
        instr_ready    = 1'b1;
        tick(3);
        chk("rst_req_valid", 16'(imem_req_valid), 16'd0);
        chk("rst_instr_valid", 16'(instr_valid), 16'd0);
        chk("rst_irq_ack", 16'(irq_ack), 16'd0);
        chk("rst_irq_epc", irq_epc, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        chk("rst_instr_data", instr_data, 16'h0000);
        chk("rst_jump", 16'(pc_jump_to), 16'd1);
        chk("rst_target", pc_target, 16'h0000);
        clear_q();
        reset = 1'b1;
        tick(8);
        pop_req(v); chk("seq_req0", v, 16'h0000);
        pop_req(v); chk("seq_req1", v, 16'h0002);
        pop_req(v); chk("seq_req2", v, 16'h0004);
        pop_ins(p, d, c0);
        chk("seq_pc0", p, 16'h0000);
        chk("seq_dat0", d, 16'h0000 ^ K);
        pop_ins(p, d, c1);
        chk("seq_pc1", p, 16'h0002);
        chk("seq_dat1", d, 16'h0002 ^ K);
        pop_ins(p, d, c2);
        chk("seq_pc2", p, 16'h0004);
        chk("seq_dat2", d, 16'h0004 ^ K);
        chk("seq_rate0", 16'(c1 - c0), 16'd2);
        chk("seq_rate1", 16'(c2 - c1), 16'd2);

        // Decode stalls after the first instruction
        do_reset();
        instr_ready = 1'b0;
        tick(6);
        chk("stl_valid", 16'(instr_valid), 16'd1);
        chk("stl_pc", instr_pc, 16'h0000);
        chk("stl_data", instr_data, 16'h0000 ^ K);
        chk("stl_req_valid", 16'(imem_req_valid), 16'd0);
        chk("stl_pc_held", pc, 16'h0002);
        chk("stl_nreq", 16'(req_q.size()), 16'd1);
        instr_ready = 1'b1;
        tick(3);
        pop_ins(p, d, c0);
        chk("stl_out_pc", p, 16'h0000);
        pop_req(v);
        pop_req(v); chk("stl_req_next", v, 16'h0002);

        // Redirect while waiting on 0x0006, two-cycle memory
        lat2 = 1'b1;
        do_reset();
        tick(11);
        chk("rdr_wait", 16'(imem_req_valid), 16'd0);
        redirect_valid  = 1'b1;
        redirect_target = 16'h0041;
        tick(1);
        redirect_valid = 1'b0;
        tick(6);
        pop_ins(p, d, c0); chk("rdr_ins0", p, 16'h0000);
        pop_ins(p, d, c0); chk("rdr_ins1", p, 16'h0002);
        pop_ins(p, d, c0); chk("rdr_ins2", p, 16'h0004);
        pop_ins(p, d, c0); chk("rdr_ins3", p, 16'h0040);
        chk("rdr_ins3_dat", d, 16'h0040 ^ K);
        repeat (3) pop_req(v);
        pop_req(v); chk("rdr_req6", v, 16'h0006);
        pop_req(v); chk("rdr_req40", v, 16'h0040);
        lat2 = 1'b0;

        // Interrupt taken in FETCH at 0x0010
        do_reset();
        tick(16);
        irq = 1'b1;
        tick(1);
        chk("irq_pc", pc, 16'h0010);
        chk("irq_ack", 16'(irq_ack), 16'd1);
        chk("irq_jump", 16'(pc_jump_to), 16'd1);
        chk("irq_target", pc_target, 16'h0100);
        chk("irq_noreq", 16'(imem_req_valid), 16'd0);
        tick(1);
        chk("irq_ack_drop", 16'(irq_ack), 16'd0);
        chk("irq_epc", irq_epc, 16'h0010);
        chk("irq_req_valid", 16'(imem_req_valid), 16'd1);
        chk("irq_req_addr", imem_req_addr, 16'h0100);
        chk("irq_flush", 16'(instr_valid), 16'd0);
        irq = 1'b0;
        tick(1);
        chk("irq_pulses", 16'(ack_cnt), 16'd1);

        // Reset asserted mid-WAIT, stale response during BOOT
        chk("mid_wait", 16'(imem_req_valid), 16'd0);
        reset = 1'b0;
        #1;
        chk("mid_instr_valid", 16'(instr_valid), 16'd0);
        chk("mid_irq_ack", 16'(irq_ack), 16'd0);
        chk("mid_req_valid", 16'(imem_req_valid), 16'd0);
        chk("mid_irq_epc", irq_epc, 16'h0000);
        chk("mid_instr_pc", instr_pc, 16'h0000);
        tick(2);
        clear_q();
        inject = 1'b1;
        reset  = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(3);
        pop_req(v); chk("boot_req0", v, 16'h0000);
        pop_ins(p, d, c0);
        chk("boot_ins_pc", p, 16'h0000);
        chk("boot_ins_dat", d, 16'h0000 ^ K);

        // HALT after fetching 0x0008, resume with run
        do_reset();
        tick(10);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        tick(3);
        chk("hlt_noreq", 16'(imem_req_valid), 16'd0);
        chk("hlt_pc", pc, 16'h000A);
        chk("hlt_nreq", 16'(req_q.size()), 16'd5);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(2);
        repeat (4) pop_req(v);
        pop_req(v); chk("hlt_req8", v, 16'h0008);
        pop_req(v); chk("hlt_resume", v, 16'h000A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
